// File: rtl/axis_h2c_byte_unpacker_pkg.sv
// Shared types and helpers for the H2C byte unpacker and the C2H byte packer.
package h2c_unpack_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int H2C_DATA_WIDTH = 64;
  localparam int H2C_KEEP_WIDTH = H2C_DATA_WIDTH / BYTE_WIDTH;
  localparam int LANE_IDX_WIDTH = (H2C_KEEP_WIDTH > 1) ? $clog2(H2C_KEEP_WIDTH) : 1;

  // Widest lane mask the helper below accepts (512-bit beats).
  localparam int MAX_LANES = 64;

  typedef logic [H2C_KEEP_WIDTH-1:0] lane_mask_t;
  typedef logic [LANE_IDX_WIDTH-1:0] lane_idx_t;

  // True when at most one bit of the mask is set (x & (x-1) clears the lowest bit).
  function automatic logic onehot_or_zero(input logic [MAX_LANES-1:0] mask);
    return (mask & (mask - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/axis_h2c_byte_unpacker_if.sv
// Stream bundle around the H2C byte unpacker: the wide H2C beat stream in,
// the one-byte stream out.
//
// Handshake: on every stream a transfer happens on a rising clock edge where
// tvalid and tready are both high. A source holding tvalid high keeps its
// payload stable until that transfer; tvalid never waits on tready, while
// tready is allowed to depend on tvalid.
interface axis_h2c_byte_unpacker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] AXIS_H2C_tdata;
  logic [KEEP_WIDTH-1:0] AXIS_H2C_tkeep;
  logic                  AXIS_H2C_tlast;
  logic                  AXIS_H2C_tvalid;
  logic                  AXIS_H2C_tready;

  logic [7:0]            BYTE_tdata;
  logic                  BYTE_tlast;
  logic                  BYTE_tvalid;
  logic                  BYTE_tready;

  // Unpacker side: sinks the H2C beats, sources the byte stream.
  modport slave (
    input  AXIS_H2C_tdata, AXIS_H2C_tkeep, AXIS_H2C_tlast, AXIS_H2C_tvalid,
    output AXIS_H2C_tready,
    output BYTE_tdata, BYTE_tlast, BYTE_tvalid,
    input  BYTE_tready
  );

  // Environment side: DMA channel feeding beats, compute logic taking bytes.
  modport master (
    output AXIS_H2C_tdata, AXIS_H2C_tkeep, AXIS_H2C_tlast, AXIS_H2C_tvalid,
    input  AXIS_H2C_tready,
    input  BYTE_tdata, BYTE_tlast, BYTE_tvalid,
    output BYTE_tready
  );

endinterface

// File: rtl/axis_h2c_byte_unpacker_lowest_set_lane.sv
// Combinational priority encoder: index of the lowest set bit of a lane mask.
// Returns 0 for an all-zero mask; callers qualify with their own empty test.
module lowest_set_lane #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     mask,
  output logic [IDX_WIDTH-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/axis_h2c_byte_unpacker.sv
// H2C byte unpacker: takes wide AXI4-Stream beats from the host-to-card DMA
// channel and replays the kept lanes one byte per cycle, lowest lane first.
// A beat sits in a holding register; a lane mask tracks which bytes are still
// owed downstream. The next beat is taken on the same cycle as the final byte
// leaves, so back-to-back beats stream with no bubble.
module axis_h2c_byte_unpacker
  import h2c_unpack_pkg::*;
#(
  parameter int DATA_WIDTH  = H2C_DATA_WIDTH,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   AXI_clock,
  input  logic                   AXI_reset,
  axis_h2c_byte_unpacker_if.slave bus,
  output logic [COUNT_WIDTH-1:0] STAT_byte_count,
  output logic                   ERR_lost_last
);

  localparam int KEEP_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH  = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

  // Holding register: the current beat and the lanes not yet emitted.
  logic [DATA_WIDTH-1:0] hold_data;
  logic [KEEP_WIDTH-1:0] hold_mask;
  logic                  hold_last;

  logic [IDX_WIDTH-1:0]  lane_idx;
  logic [KEEP_WIDTH-1:0] mask_after_byte;
  logic [7:0]            byte_sel;
  logic                  empty;
  logic                  single_lane;
  logic                  byte_fire;
  logic                  beat_fire;
  logic                  in_ready;

  lowest_set_lane #(
    .WIDTH     (KEEP_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_lowest_set_lane (
    .mask (hold_mask),
    .idx  (lane_idx)
  );

  assign empty       = (hold_mask == '0);
  assign single_lane = !empty && onehot_or_zero(MAX_LANES'(hold_mask));

  // Select the byte of the lowest pending lane.
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (lane_idx == IDX_WIDTH'(i)) begin
        byte_sel = hold_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Retire the lane being handed off this cycle.
  always_comb begin
    mask_after_byte           = hold_mask;
    mask_after_byte[lane_idx] = 1'b0;
  end

  // Outputs depend only on registered state; tready also sees reset and the
  // downstream ready so the refill lands on the final byte's cycle.
  assign byte_fire = !empty && bus.BYTE_tready;
  assign in_ready  = !AXI_reset && (empty || (byte_fire && single_lane));
  assign beat_fire = bus.AXIS_H2C_tvalid && in_ready;

  assign bus.AXIS_H2C_tready = in_ready;
  assign bus.BYTE_tvalid     = !empty;
  assign bus.BYTE_tdata      = byte_sel;
  assign bus.BYTE_tlast      = hold_last && single_lane;

  // Holding register: a new beat overrides the final-byte clear.
  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      hold_data <= '0;
      hold_mask <= '0;
      hold_last <= 1'b0;
    end else if (beat_fire) begin
      hold_data <= bus.AXIS_H2C_tdata;
      hold_mask <= bus.AXIS_H2C_tkeep;
      hold_last <= bus.AXIS_H2C_tlast;
    end else if (byte_fire) begin
      hold_mask <= mask_after_byte;
    end
  end

  // Running count of bytes handed downstream; wraps naturally.
  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      STAT_byte_count <= '0;
    end else if (byte_fire) begin
      STAT_byte_count <= STAT_byte_count + COUNT_WIDTH'(1);
    end
  end

  // One-cycle flag when a packet end arrives on a beat with no bytes to carry it.
  always_ff @(posedge AXI_clock or posedge AXI_reset) begin
    if (AXI_reset) begin
      ERR_lost_last <= 1'b0;
    end else begin
      ERR_lost_last <= beat_fire && bus.AXIS_H2C_tlast && (bus.AXIS_H2C_tkeep == '0);
    end
  end

endmodule
